opc5ls_intctl: RTL and testbench

Memory-mapped interrupt controller for the OPC5LS CPU. Collects up to NSRC external interrupt sources and applies per-source enable and edge/level selection. Arbitrates by fixed priority and drives the CPU's single `int_b` line. The handler identifies the source through a claim read and releases it with a complete (EOI) write, so the controller sequences one interrupt at a time in step with the CPU's non-nested ISR model.

---
 rtl/opc5ls_intctl_pkg.sv | 37 +++
 rtl/opc5ls_intctl_src.sv | 49 ++++
 rtl/opc5ls_intctl.sv | 149 ++++++++++++++
 tb/tb_opc5ls_intctl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/opc5ls_intctl_pkg.sv
// Shared constants, state encoding and claim-word layout for the OPC5LS interrupt controller.
package opc5ls_intctl_pkg;

    localparam int unsigned DATA_W          = 16;
    localparam int unsigned OFF_W           = 3;
    localparam int unsigned ID_W            = 4;
    localparam int unsigned CLAIM_VALID_BIT = 15;
    localparam int unsigned INT_B_BIT       = 0;

    localparam logic [OFF_W-1:0] REG_PENDING = OFF_W'(0);
    localparam logic [OFF_W-1:0] REG_ENABLE  = OFF_W'(1);
    localparam logic [OFF_W-1:0] REG_EDGE    = OFF_W'(2);
    localparam logic [OFF_W-1:0] REG_CLAIM   = OFF_W'(3);
    localparam logic [OFF_W-1:0] REG_ACTIVE  = OFF_W'(4);

    // Bit INT_B_BIT of the encoding is the int_b level, so the pin is a bare flop output.
    typedef enum logic [1:0] {
        IDLE    = 2'b01,
        REQ     = 2'b00,
        CLAIMED = 2'b11
    } state_t;

    typedef struct packed {
        logic                                valid;
        logic [CLAIM_VALID_BIT-ID_W-1:0]     rsvd;
        logic [ID_W-1:0]                     id;
    } claim_word_t;

    function automatic claim_word_t make_claim(input logic valid, input logic [ID_W-1:0] id);
        claim_word_t w;
        w.valid = valid;
        w.rsvd  = '0;
        w.id    = id;
        return w;
    endfunction

endpackage

// File: rtl/opc5ls_intctl_src.sv
// One interrupt source: optional two-flop synchroniser (OPC5LS_INTCTL_SYNC_EN), edge detect
// and the edge-latched / level-following pending bit.
module opc5ls_intctl_src (
    input  logic clk,
    input  logic reset_b,
    input  logic irq,
    input  logic edge_mode,
    input  logic clr,
    output logic pending
);

    logic lvl;
    logic prev_q;
    logic rise;

`ifdef OPC5LS_INTCTL_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], irq};
        end
    end

    assign lvl = sync_q[1];
`else
    assign lvl = irq;
`endif

    assign rise = lvl & ~prev_q;

    // A coincident rise beats a clear so a fresh edge is never lost.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            prev_q  <= 1'b0;
            pending <= 1'b0;
        end else begin
            prev_q <= lvl;
            if (edge_mode) begin
                pending <= rise | (pending & ~clr);
            end else begin
                pending <= lvl;
            end
        end
    end

endmodule

// File: rtl/opc5ls_intctl.sv
// OPC5LS memory-mapped interrupt controller: register file, fixed-priority arbiter,
// claim/complete FSM and combinational read mux. Optional input sync via OPC5LS_INTCTL_SYNC_EN.
module opc5ls_intctl
    import opc5ls_intctl_pkg::*;
#(
    parameter int unsigned  NSRC = 8,
    parameter logic [15:0]  BASE = 16'hFF00
) (
    input  logic            clk,
    input  logic            reset_b,
    input  logic [15:0]     address,
    input  logic            rnw,
    input  logic [15:0]     wdata,
    output logic [15:0]     rdata,
    output logic            cs,
    input  logic [NSRC-1:0] irq_src,
    output logic            int_b
);

    logic [OFF_W-1:0] offset;
    logic             wr_en;
    logic             rd_claim;

    logic [NSRC-1:0]  enable_q;
    logic [NSRC-1:0]  edge_q;
    logic [NSRC-1:0]  pending;
    logic [NSRC-1:0]  w1c;
    logic [NSRC-1:0]  clr;
    logic [NSRC-1:0]  svc_mask;
    logic [NSRC-1:0]  cand_vec;
    logic             cand_valid;
    logic [ID_W-1:0]  cand_id;

    state_t           state_q;
    state_t           state_d;
    logic [ID_W-1:0]  act_id_q;
    logic [ID_W-1:0]  act_id_d;
    logic             claim_take;
    logic             complete;

    logic             unused_wdata;

    assign offset       = address[OFF_W-1:0];
    assign cs           = (address[15:OFF_W] == BASE[15:OFF_W]);
    assign wr_en        = cs & ~rnw;
    assign rd_claim     = cs & rnw & (offset == REG_CLAIM);
    assign w1c          = (wr_en && offset == REG_PENDING) ? wdata[NSRC-1:0] : '0;
    assign int_b        = state_q[INT_B_BIT];
    assign unused_wdata = ^wdata;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            enable_q <= '0;
            edge_q   <= '0;
        end else if (wr_en) begin
            if (offset == REG_ENABLE) enable_q <= wdata[NSRC-1:0];
            if (offset == REG_EDGE)   edge_q   <= wdata[NSRC-1:0];
        end
    end

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        opc5ls_intctl_src u_src (
            .clk       (clk),
            .reset_b   (reset_b),
            .irq       (irq_src[g]),
            .edge_mode (edge_q[g]),
            .clr       (clr[g]),
            .pending   (pending[g])
        );
    end

    // Lowest pending & enabled index wins; the id in service is never re-offered.
    always_comb begin
        svc_mask = '0;
        cand_id  = '0;
        for (int i = 0; i < int'(NSRC); i++) begin
            svc_mask[i] = (state_q == CLAIMED) && (act_id_q == ID_W'(i));
        end
        cand_vec   = pending & enable_q & ~svc_mask;
        cand_valid = |cand_vec;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (cand_vec[i]) cand_id = ID_W'(i);
        end
    end

    always_comb begin
        clr = w1c;
        for (int i = 0; i < int'(NSRC); i++) begin
            if (claim_take && (cand_id == ID_W'(i))) clr[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q  <= IDLE;
            act_id_q <= '0;
        end else begin
            state_q  <= state_d;
            act_id_q <= act_id_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        act_id_d   = act_id_q;
        claim_take = rd_claim && (state_q == REQ) && cand_valid;
        complete   = wr_en && (offset == REG_CLAIM) && (state_q == CLAIMED) &&
                     (wdata[ID_W-1:0] == act_id_q);
        case (state_q)
            IDLE: begin
                if (cand_valid) state_d = REQ;
            end
            REQ: begin
                if (claim_take) begin
                    state_d  = CLAIMED;
                    act_id_d = cand_id;
                end else if (!cand_valid) begin
                    state_d = IDLE;
                end
            end
            CLAIMED: begin
                if (complete) begin
                    state_d  = IDLE;
                    act_id_d = '0;
                end
            end
            default: begin
                state_d  = IDLE;
                act_id_d = '0;
            end
        endcase
    end

    always_comb begin
        rdata = '0;
        if (cs) begin
            case (offset)
                REG_PENDING: rdata = 16'(pending);
                REG_ENABLE:  rdata = 16'(enable_q);
                REG_EDGE:    rdata = 16'(edge_q);
                REG_CLAIM:   rdata = make_claim((state_q == REQ) && cand_valid,
                                                ((state_q == REQ) && cand_valid) ? cand_id : '0);
                REG_ACTIVE:  rdata = make_claim(state_q == CLAIMED, act_id_q);
                default:     rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_opc5ls_intctl.sv
// Directed self-checking bench for opc5ls_intctl; timing expectations follow OPC5LS_INTCTL_SYNC_EN.
module tb_opc5ls_intctl;

    localparam int unsigned NSRC      = 8;
    localparam logic [15:0] BASE      = 16'hFF00;
    localparam logic [15:0] IDLE_ADDR = 16'h0100;
`ifdef OPC5LS_INTCTL_SYNC_EN
    localparam int SYNC_DLY = 2;
`else
    localparam int SYNC_DLY = 0;
`endif

    logic            clk = 1'b0;
    logic            reset_b;
    logic [15:0]     address;
    logic            rnw;
    logic [15:0]     wdata;
    logic [15:0]     rdata;
    logic            cs;
    logic [NSRC-1:0] irq_src;
    logic            int_b;

    int n_tests = 0;
    int n_fail  = 0;

    opc5ls_intctl #(.NSRC(NSRC), .BASE(BASE)) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .address (address),
        .rnw     (rnw),
        .wdata   (wdata),
        .rdata   (rdata),
        .cs      (cs),
        .irq_src (irq_src),
        .int_b   (int_b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] off, input logic [15:0] d);
        address = BASE + 16'(off);
        rnw     = 1'b0;
        wdata   = d;
        tick();
        address = IDLE_ADDR;
        rnw     = 1'b1;
        wdata   = '0;
    endtask

    // Non-claim read between edges; no side effects.
    task automatic rd(input string tag, input logic [2:0] off, input logic [15:0] exp);
        @(negedge clk);
        address = BASE + 16'(off);
        rnw     = 1'b1;
        #1;
        chk(tag, rdata, exp);
        address = IDLE_ADDR;
    endtask

    // Claim read held across one active edge.
    task automatic claim(input string tag, input logic [15:0] exp);
        @(negedge clk);
        address = BASE + 16'd3;
        rnw     = 1'b1;
        #1;
        chk(tag, rdata, exp);
        tick();
        address = IDLE_ADDR;
    endtask

    initial begin
        reset_b = 1'b0;
        address = IDLE_ADDR;
        rnw     = 1'b1;
        wdata   = '0;
        irq_src = '0;
        repeat (3) tick();
        reset_b = 1'b1;
        tick();

        // Reset state
        chk("rst_int_b", 16'(int_b), 16'h0001);
        chk("rst_cs_idle", 16'(cs), 16'h0000);
        for (int i = 0; i < 8; i++) rd($sformatf("rst_reg%0d", i), 3'(i), 16'h0000);

        // Masked edge source still latches pending
        wr(3'd2, 16'h0004);
        irq_src = 8'h04; tick(); irq_src = '0;
        repeat (SYNC_DLY + 2) tick();
        chk("masked_int_b", 16'(int_b), 16'h0001);
        rd("masked_pend", 3'd0, 16'h0004);
        wr(3'd0, 16'h0004);
        rd("w1c_clear", 3'd0, 16'h0000);
        wr(3'd5, 16'hFFFF);
        rd("rsvd_reg5", 3'd5, 16'h0000);

        // Simultaneous edges on 5 and 3: priority and latency
        wr(3'd1, 16'h00FF);
        wr(3'd2, 16'h00FF);
        rd("enable_rb", 3'd1, 16'h00FF);
        irq_src = 8'h28; tick();
        chk("lat_capture", 16'(int_b), 16'h0001);
        irq_src = '0;
        repeat (SYNC_DLY) tick();
        chk("lat_pre_req", 16'(int_b), 16'h0001);
        tick();
        chk("lat_req", 16'(int_b), 16'h0000);
        rd("pend_two", 3'd0, 16'h0028);
        claim("claim3", 16'h8003);
        chk("claim3_int_b", 16'(int_b), 16'h0001);
        rd("pend_after3", 3'd0, 16'h0020);
        rd("active3", 3'd4, 16'h8003);
        wr(3'd3, 16'h0003);
        chk("cmpl3_idle", 16'(int_b), 16'h0001);
        tick();
        chk("cmpl3_req5", 16'(int_b), 16'h0000);
        rd("active_cleared", 3'd4, 16'h0000);
        claim("claim5", 16'h8005);
        wr(3'd3, 16'h0005);
        chk("cmpl5_idle", 16'(int_b), 16'h0001);
        tick();
        chk("cmpl5_stay", 16'(int_b), 16'h0001);
        rd("pend_empty", 3'd0, 16'h0000);

        // Level source 1
        wr(3'd2, 16'h00FD);
        irq_src = 8'h02;
        repeat (SYNC_DLY + 2) tick();
        chk("lvl_req", 16'(int_b), 16'h0000);
        claim("claim1", 16'h8001);
        chk("claim1_int_b", 16'(int_b), 16'h0001);
        rd("lvl_pend_kept", 3'd0, 16'h0002);
        wr(3'd3, 16'h0001);
        chk("lvl_cmpl_idle", 16'(int_b), 16'h0001);
        tick();
        chk("lvl_reassert", 16'(int_b), 16'h0000);
        irq_src = '0;
        repeat (SYNC_DLY + 1) tick();
        chk("lvl_drop_hold", 16'(int_b), 16'h0000);
        tick();
        chk("lvl_drop_idle", 16'(int_b), 16'h0001);
        rd("lvl_pend_gone", 3'd0, 16'h0000);

        // Mismatched complete and claim in CLAIMED
        irq_src = 8'h40; tick(); irq_src = '0;
        repeat (SYNC_DLY + 1) tick();
        chk("src6_req", 16'(int_b), 16'h0000);
        claim("claim6", 16'h8006);
        wr(3'd3, 16'h0004);
        rd("bad_cmpl_active", 3'd4, 16'h8006);
        chk("bad_cmpl_int_b", 16'(int_b), 16'h0001);
        claim("claim_in_claimed", 16'h0000);
        rd("active_still6", 3'd4, 16'h8006);
        wr(3'd3, 16'h0006);
        rd("cmpl6_active", 3'd4, 16'h0000);
        chk("cmpl6_int_b", 16'(int_b), 16'h0001);

        // W1C coinciding with a new edge on src 7
        wr(3'd1, 16'h0000);
        irq_src = 8'h80; tick(); irq_src = '0;
        repeat (SYNC_DLY + 1) tick();
        rd("pend7_set", 3'd0, 16'h0080);
        irq_src = 8'h80;
        repeat (SYNC_DLY) tick();
        wr(3'd0, 16'h0080);
        rd("w1c_vs_edge", 3'd0, 16'h0080);
        irq_src = '0;
        repeat (SYNC_DLY + 1) tick();
        wr(3'd0, 16'h0080);
        rd("w1c_plain", 3'd0, 16'h0000);
        chk("masked7_int_b", 16'(int_b), 16'h0001);

        // Asynchronous reset mid-ISR
        wr(3'd1, 16'h00FF);
        irq_src = 8'h10; tick(); irq_src = '0;
        repeat (SYNC_DLY + 1) tick();
        claim("claim4", 16'h8004);
        rd("active4", 3'd4, 16'h8004);
        #2;
        reset_b = 1'b0;
        #1;
        chk("arst_int_b", 16'(int_b), 16'h0001);
        rd("arst_pend", 3'd0, 16'h0000);
        rd("arst_enable", 3'd1, 16'h0000);
        rd("arst_edge", 3'd2, 16'h0000);
        rd("arst_claim", 3'd3, 16'h0000);
        rd("arst_active", 3'd4, 16'h0000);

        // Address decode outside the window
        address = IDLE_ADDR; #1;
        chk("far_cs", 16'(cs), 16'h0000);
        chk("far_rdata", rdata, 16'h0000);
        address = BASE + 16'd8; #1;
        chk("above_cs", 16'(cs), 16'h0000);
        address = BASE - 16'd1; #1;
        chk("below_cs", 16'(cs), 16'h0000);
        chk("below_rdata", rdata, 16'h0000);
        address = BASE + 16'd7; #1;
        chk("top_cs", 16'(cs), 16'h0001);
        address = IDLE_ADDR;
        @(negedge clk);
        reset_b = 1'b1;
        tick();
        chk("post_rst_int_b", 16'(int_b), 16'h0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
